// File: rtl/bic_pkg.sv
//------------------------------------------------------------------------------
// Module : bic_pkg
// Brief  : Shared constants, threshold helper and decision type for the
//          bus-invert transmit stage.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package bic_pkg;

    localparam int BIC_DEF_WIDTH = 8;

    // Inversion threshold: invert only when more than half the lines would toggle.
    function automatic int bic_threshold(input int width);
        return width / 2;
    endfunction

    typedef struct packed {
        logic                     inv;
        logic [BIC_DEF_WIDTH-1:0] coded;
    } bic_decision_t;

endpackage

`default_nettype wire

// File: rtl/bus_invert_popcount.sv
//------------------------------------------------------------------------------
// Module : bus_invert_popcount
// Brief  : Combinational population count built as a recursive adder tree.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module bus_invert_popcount #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]           i_bits,
    output logic [$clog2(WIDTH+1)-1:0] o_count
);

    localparam int c_CNT_W = $clog2(WIDTH + 1);

    generate
        if (WIDTH == 1) begin : g_leaf
            assign o_count = i_bits;
        end else begin : g_node
            localparam int c_LO_W = WIDTH / 2;
            localparam int c_HI_W = WIDTH - c_LO_W;

            logic [$clog2(c_LO_W+1)-1:0] w_lo;
            logic [$clog2(c_HI_W+1)-1:0] w_hi;

            bus_invert_popcount #(.WIDTH(c_LO_W)) u_lo (
                .i_bits  (i_bits[c_LO_W-1:0]),
                .o_count (w_lo)
            );

            bus_invert_popcount #(.WIDTH(c_HI_W)) u_hi (
                .i_bits  (i_bits[WIDTH-1:c_LO_W]),
                .o_count (w_hi)
            );

            assign o_count = c_CNT_W'(w_lo) + c_CNT_W'(w_hi);
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/bus_invert_tx_stage.sv
//------------------------------------------------------------------------------
// Module : bus_invert_tx_stage
// Brief  : Registered bus-invert coded transmit stage with valid/ready input.
//          Optional toggle statistics enabled by `TOGGLE_STATS_EN.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module bus_invert_tx_stage
    import bic_pkg::*;
#(
    parameter int WIDTH     = BIC_DEF_WIDTH,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     bus_data,
    output logic                 bus_inv,
    output logic                 bus_valid,
    input  logic                 bus_ready,
    input  logic                 stat_clr,
    output logic [CNT_WIDTH-1:0] raw_toggles,
    output logic [CNT_WIDTH-1:0] bus_toggles
);

    localparam int c_PC_W = $clog2(WIDTH + 1);

    typedef struct packed {
        logic             inv;
        logic [WIDTH-1:0] coded;
    } decision_t;

    logic [WIDTH-1:0]  r_bus_data;
    logic              r_bus_inv;
    logic              r_bus_valid;
    logic              w_accept;
    logic [c_PC_W-1:0] w_hd;
    decision_t         w_dec;

    assign in_ready = !r_bus_valid || bus_ready;
    assign w_accept = in_valid && in_ready;

    // Distance is taken against the lines actually driven, not the raw history.
    bus_invert_popcount #(.WIDTH(WIDTH)) u_pc_dec (
        .i_bits  (in_data ^ r_bus_data),
        .o_count (w_hd)
    );

    assign w_dec.inv   = (w_hd > c_PC_W'(bic_threshold(WIDTH)));
    assign w_dec.coded = w_dec.inv ? ~in_data : in_data;

    // Lines hold their last value when idle so the next decision stays valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bus_data  <= '0;
            r_bus_inv   <= 1'b0;
            r_bus_valid <= 1'b0;
        end else if (w_accept) begin
            r_bus_data  <= w_dec.coded;
            r_bus_inv   <= w_dec.inv;
            r_bus_valid <= 1'b1;
        end else if (bus_ready) begin
            r_bus_valid <= 1'b0;
        end
    end

    assign bus_data  = r_bus_data;
    assign bus_inv   = r_bus_inv;
    assign bus_valid = r_bus_valid;

`ifdef TOGGLE_STATS_EN
    logic [WIDTH-1:0]     r_raw_shadow;
    logic [CNT_WIDTH-1:0] r_raw_cnt;
    logic [CNT_WIDTH-1:0] r_bus_cnt;
    logic [c_PC_W-1:0]    w_raw_pc;
    logic [c_PC_W-1:0]    w_bus_pc;
    logic [c_PC_W:0]      w_bus_inc;

    function automatic logic [CNT_WIDTH-1:0] sat_add(
        input logic [CNT_WIDTH-1:0] a,
        input logic [CNT_WIDTH-1:0] b
    );
        logic [CNT_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
    endfunction

    bus_invert_popcount #(.WIDTH(WIDTH)) u_pc_raw (
        .i_bits  (in_data ^ r_raw_shadow),
        .o_count (w_raw_pc)
    );

    bus_invert_popcount #(.WIDTH(WIDTH)) u_pc_bus (
        .i_bits  (w_dec.coded ^ r_bus_data),
        .o_count (w_bus_pc)
    );

    assign w_bus_inc = {1'b0, w_bus_pc} + (c_PC_W+1)'(w_dec.inv ^ r_bus_inv);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_raw_shadow <= '0;
            r_raw_cnt    <= '0;
            r_bus_cnt    <= '0;
        end else begin
            if (w_accept) begin
                r_raw_shadow <= in_data;
            end
            if (stat_clr) begin
                r_raw_cnt <= '0;
                r_bus_cnt <= '0;
            end else if (w_accept) begin
                r_raw_cnt <= sat_add(r_raw_cnt, CNT_WIDTH'(w_raw_pc));
                r_bus_cnt <= sat_add(r_bus_cnt, CNT_WIDTH'(w_bus_inc));
            end
        end
    end

    assign raw_toggles = r_raw_cnt;
    assign bus_toggles = r_bus_cnt;
`else
    logic w_unused_stat_clr;

    assign w_unused_stat_clr = stat_clr;
    assign raw_toggles       = '0;
    assign bus_toggles       = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bus_invert_tx_stage.sv
//------------------------------------------------------------------------------
// Module : tb_bus_invert_tx_stage
// Brief  : Directed self-checking bench for bus_invert_tx_stage.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_bus_invert_tx_stage;

    logic        clk;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  bus_data;
    logic        bus_inv;
    logic        bus_valid;
    logic        bus_ready;
    logic        stat_clr;
    logic [31:0] raw_toggles;
    logic [31:0] bus_toggles;

    int n_tests = 0;
    int n_fail  = 0;

    bus_invert_tx_stage #(.WIDTH(8), .CNT_WIDTH(32)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .bus_data    (bus_data),
        .bus_inv     (bus_inv),
        .bus_valid   (bus_valid),
        .bus_ready   (bus_ready),
        .stat_clr    (stat_clr),
        .raw_toggles (raw_toggles),
        .bus_toggles (bus_toggles)
    );

`ifdef TOGGLE_STATS_EN
    logic [7:0] s_in_data;
    logic       s_in_valid;
    logic       s_in_ready;
    logic [7:0] s_bus_data;
    logic       s_bus_inv;
    logic       s_bus_valid;
    logic       s_bus_ready;
    logic       s_stat_clr;
    logic [3:0] s_raw_toggles;
    logic [3:0] s_bus_toggles;

    bus_invert_tx_stage #(.WIDTH(8), .CNT_WIDTH(4)) u_sat (
        .clk         (clk),
        .rst         (rst),
        .in_data     (s_in_data),
        .in_valid    (s_in_valid),
        .in_ready    (s_in_ready),
        .bus_data    (s_bus_data),
        .bus_inv     (s_bus_inv),
        .bus_valid   (s_bus_valid),
        .bus_ready   (s_bus_ready),
        .stat_clr    (s_stat_clr),
        .raw_toggles (s_raw_toggles),
        .bus_toggles (s_bus_toggles)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_bus(input string tag, input logic [7:0] d, input logic inv, input logic vld);
        check({tag, ".data"},  32'(bus_data),  32'(d));
        check({tag, ".inv"},   32'(bus_inv),   32'(inv));
        check({tag, ".valid"}, 32'(bus_valid), 32'(vld));
    endtask

    // Counters read as 0 when the statistics feature is compiled out.
    task automatic check_stats(input string tag, input int exp_raw, input int exp_bus);
`ifdef TOGGLE_STATS_EN
        check({tag, ".raw_toggles"}, raw_toggles, 32'(exp_raw));
        check({tag, ".bus_toggles"}, bus_toggles, 32'(exp_bus));
`else
        check({tag, ".raw_toggles"}, raw_toggles, 32'(exp_raw * 0));
        check({tag, ".bus_toggles"}, bus_toggles, 32'(exp_bus * 0));
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        bus_ready = 1'b1;
        stat_clr  = 1'b0;
`ifdef TOGGLE_STATS_EN
        s_in_data   = 8'h00;
        s_in_valid  = 1'b0;
        s_bus_ready = 1'b1;
        s_stat_clr  = 1'b0;
`endif
        #1;
        check_bus("reset", 8'h00, 1'b0, 1'b0);
        check("reset.in_ready", 32'(in_ready), 32'd1);
        check_stats("reset", 0, 0);
        tick();
        tick();
        rst = 1'b0;

        // Tie at hd=4 does not invert
        in_data  = 8'h0F;
        in_valid = 1'b1;
        tick();
        check_bus("t1", 8'h0F, 1'b0, 1'b1);
        check_stats("t1", 4, 4);

        // hd=7 inverts
        in_data = 8'hF1;
        tick();
        check_bus("t2", 8'h0E, 1'b1, 1'b1);
        check_stats("t2", 11, 6);

        // Stall for three cycles with a pending word
        in_data   = 8'h3C;
        bus_ready = 1'b0;
        #1;
        check("t3.stall_in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_bus("t3.stall", 8'h0E, 1'b1, 1'b1);
            check("t3.stall_ready", 32'(in_ready), 32'd0);
        end
        check_stats("t3.stall", 11, 6);
        bus_ready = 1'b1;
        #1;
        check("t3.release_in_ready", 32'(in_ready), 32'd1);
        tick();
        check_bus("t3.release", 8'h3C, 1'b0, 1'b1);
        check_stats("t3.release", 16, 10);
        in_valid = 1'b0;
        tick();
        check_bus("t3.drain", 8'h3C, 1'b0, 1'b0);
        check_stats("t3.drain", 16, 10);

        // Full-rate stream; clear with the first accept, clear wins
        in_valid = 1'b1;
        in_data  = 8'h00;
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        check_bus("t4.w0", 8'h00, 1'b0, 1'b1);
        check_stats("t4.clr_accept", 0, 0);
        in_data = 8'hFF;
        tick();
        check_bus("t4.w1", 8'h00, 1'b1, 1'b1);
        in_data = 8'h00;
        tick();
        check_bus("t4.w2", 8'h00, 1'b0, 1'b1);
        in_data = 8'hFF;
        tick();
        check_bus("t4.w3", 8'h00, 1'b1, 1'b1);
        check_stats("t4.stream", 24, 3);
        in_valid = 1'b0;
        tick();
        check_bus("t4.idle_hold", 8'h00, 1'b1, 1'b0);

        // Asynchronous reset during a stall
        in_valid = 1'b1;
        in_data  = 8'hAA;
        tick();
        check_bus("t5.pre", 8'hAA, 1'b0, 1'b1);
        in_data   = 8'h55;
        bus_ready = 1'b0;
        tick();
        check_bus("t5.stall", 8'hAA, 1'b0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_bus("t5.async_rst", 8'h00, 1'b0, 1'b0);
        check_stats("t5.async_rst", 0, 0);
        tick();
        rst       = 1'b0;
        bus_ready = 1'b1;
        in_data   = 8'hFE;
        tick();
        check_bus("t5.post_rst", 8'h01, 1'b1, 1'b1);
        check_stats("t5.post_rst", 7, 2);

        // hd=4 tie, hd=8, hd=5 boundary cases
        in_data = 8'h1F;
        tick();
        check_bus("b.tie", 8'h1F, 1'b0, 1'b1);
        check_stats("b.tie", 11, 7);
        in_data = 8'hE0;
        tick();
        check_bus("b.hd8", 8'h1F, 1'b1, 1'b1);
        check_stats("b.hd8", 19, 8);
        in_data = 8'h00;
        tick();
        check_bus("b.hd5", 8'hFF, 1'b1, 1'b1);
        check_stats("b.hd5", 22, 11);
        in_valid = 1'b0;
        tick();
        check_bus("b.drain", 8'hFF, 1'b1, 1'b0);

`ifdef TOGGLE_STATS_EN
        // Saturation on a 4-bit counter instance
        s_in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            s_in_data = i[0] ? 8'h00 : 8'hFF;
            tick();
            if (i == 1) begin
                check("sat.raw_early", 32'(s_raw_toggles), 32'd15);
                check("sat.bus_early", 32'(s_bus_toggles), 32'd2);
            end
        end
        check("sat.raw", 32'(s_raw_toggles), 32'd15);
        check("sat.bus", 32'(s_bus_toggles), 32'd15);
        s_in_data  = 8'hFF;
        s_stat_clr = 1'b1;
        tick();
        s_stat_clr = 1'b0;
        s_in_valid = 1'b0;
        check("sat.clr_raw", 32'(s_raw_toggles), 32'd0);
        check("sat.clr_bus", 32'(s_bus_toggles), 32'd0);
        check("sat.clr_bus_data", 32'(s_bus_data), 32'h00);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
